quad_decoder: RTL
=================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter WIDTH, default 4, sets the width of the position count.
REQ-002 Parameter SYNC_STAGES, default 2, sets the number of synchronizer flops per quadrature input (legal range 2..4).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 quad_a  input  1  quadrature channel A, asynchronous to clk.
REQ-006 quad_b  input  1  quadrature channel B, asynchronous to clk.
REQ-007 clear  input  1  synchronous clear of count and err, active-high.
REQ-008 step  output  1  one-cycle pulse per legal quadrature transition, usable as an up/down counter enable.
REQ-009 up_down  output  1  direction of the last legal transition: 1 = up, 0 = down.
REQ-010 count  output  WIDTH  signed-agnostic position count, modulo 2^WIDTH.
REQ-011 err  output  1  sticky flag for an illegal (double-bit) transition.

Function
REQ-012 Each of quad_a and quad_b SHALL pass through its own SYNC_STAGES-flop synchronizer; only synchronized values SHALL be used.
REQ-013 The state pair is {A,B}; the up sequence SHALL be 00->10->11->01->00 (A leads B), and the down sequence is its reverse.
REQ-014 The FSM SHALL have two states: INIT, which loads the previous-sample register from the synchronized inputs with no step, then moves unconditionally to TRACK next cycle; and TRACK.
REQ-015 In TRACK, a single-bit change matching the up sequence SHALL assert step=1, set up_down=1, and increment count by 1.
REQ-016 In TRACK, a single-bit change matching the down sequence SHALL assert step=1, set up_down=0, and decrement count by 1.
REQ-017 In TRACK, no change SHALL produce step=0, with up_down and count held.
REQ-018 In TRACK, a change of both bits in one sample SHALL set err=1 and produce step=0, with count and up_down unchanged; the previous-sample register SHALL still update.
REQ-019 The previous-sample register SHALL update every cycle in TRACK.
REQ-020 Latency: a pin level stable before rising edge N SHALL cause step, count and up_down to update at edge N+SYNC_STAGES.
REQ-021 step SHALL be high for exactly one clk cycle per legal transition; back-to-back legal transitions on consecutive cycles SHALL give consecutive step pulses.
REQ-022 count SHALL wrap: all-ones + up -> 0, and 0 + down -> all-ones; no saturation and no overflow flag.
REQ-023 clear=1 SHALL set count=0 and err=0 at the next edge, taking priority over a simultaneous step.
REQ-024 When clear coincides with a legal transition, step and up_down SHALL still update.
REQ-025 clear SHALL NOT change FSM state or synchronizer contents.
REQ-026 err SHALL remain 1 until clear or reset.

Reset
REQ-027 While reset=0: all synchronizer flops = 0, previous sample = 00, FSM = INIT, step = 0, up_down = 1, count = 0, err = 0.
REQ-028 Reset asserted mid-transition SHALL take effect immediately, without waiting for clk.
REQ-029 After reset deassertion, no step SHALL be generated until a transition is seen relative to the sample captured in INIT.

Structure
REQ-030 Shared package quad_pkg SHALL hold the FSM state type (INIT, TRACK), the 2-bit quadrature phase constants, and the direction constants DIR_UP=1 and DIR_DOWN=0.
REQ-031 One sub-module, sync_ff (parameterized depth, 1-bit, async active-low reset), SHALL be instantiated once per channel.
REQ-032 The decode SHALL be a combinational function of {previous, current} mapped to {legal, dir}, kept inside quad_decoder.

Verification
REQ-033 Reset with A=B=1, release, hold inputs 20 cycles -> step never asserts, count=0, err=0, up_down=1.
REQ-034 Drive 5 full up cycles (20 transitions, each held 4 clk) -> 20 step pulses, up_down=1, count=4 (20 mod 16), each update SYNC_STAGES edges after the pin change.
REQ-035 From count=0, drive 3 down transitions -> count=13, up_down=0, 3 step pulses.
REQ-036 Drive 00->11 in a single sample -> err=1, no step, count unchanged; later legal transitions still count; clear -> err=0, count=0.
REQ-037 Assert clear on the same edge as a legal up step with count=7 -> count=0, step=1, up_down=1.
REQ-038 Assert reset asynchronously between clk edges mid-sequence -> all outputs take reset values before the next edge; after release, the first step occurs only on the next transition.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder: FSM states,
// the four {A,B} phase codes and the direction encoding.
package quad_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } quad_state_t;

    // Phase codes in up order; the down sequence walks this list backwards.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// DEPTH must be at least 2.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B, tracks the previous phase and produces
// step/direction pulses, a wrapping position count and a sticky error flag.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clear,
    output logic             step,
    output logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             err,
    output quad_state_t      state
);

    logic       a_sync;
    logic       b_sync;
    logic [1:0] cur;
    logic [1:0] prev;
    logic [1:0] dec;
    logic [2:0] prime_cnt;

    quad_state_t      state_nxt;
    logic [1:0]       prev_nxt;
    logic [2:0]       prime_nxt;
    logic             step_nxt;
    logic             dir_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             err_nxt;

    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .d     (quad_a),
        .q     (a_sync)
    );

    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .d     (quad_b),
        .q     (b_sync)
    );

    assign cur = {a_sync, b_sync};

    // Returns {legal, dir}; no-change and double-bit changes are both not legal.
    function automatic logic [1:0] decode(input logic [1:0] prv, input logic [1:0] nxt);
        case ({prv, nxt})
            {PH_00, PH_10}, {PH_10, PH_11},
            {PH_11, PH_01}, {PH_01, PH_00}: decode = {1'b1, DIR_UP};
            {PH_00, PH_01}, {PH_01, PH_11},
            {PH_11, PH_10}, {PH_10, PH_00}: decode = {1'b1, DIR_DOWN};
            default:                        decode = 2'b00;
        endcase
    endfunction

    assign dec = decode(prev, cur);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            prev      <= PH_00;
            prime_cnt <= '0;
            step      <= 1'b0;
            up_down   <= DIR_UP;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            prime_cnt <= prime_nxt;
            step      <= step_nxt;
            up_down   <= dir_nxt;
            count     <= count_nxt;
            err       <= err_nxt;
        end
    end

    // INIT keeps reloading the previous sample until the synchronizers hold
    // real pin levels, so pins that are non-zero at reset release never look
    // like a transition; the last INIT cycle captures the reference sample.
    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        prime_nxt = prime_cnt;
        step_nxt  = 1'b0;
        dir_nxt   = up_down;
        count_nxt = count;
        err_nxt   = err;

        case (state)
            INIT: begin
                prev_nxt = cur;
                if (prime_cnt == 3'(SYNC_STAGES)) begin
                    state_nxt = TRACK;
                end else begin
                    prime_nxt = prime_cnt + 3'd1;
                end
            end
            TRACK: begin
                prev_nxt = cur;
                if (dec[1]) begin
                    step_nxt  = 1'b1;
                    dir_nxt   = dec[0];
                    count_nxt = dec[0] ? count + WIDTH'(1) : count - WIDTH'(1);
                end else if (prev != cur) begin
                    err_nxt = 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase

        // clear wins over a same-cycle step for count, but step/dir still report it.
        if (clear) begin
            count_nxt = '0;
            err_nxt   = 1'b0;
        end
    end

endmodule
